// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front-end. Issues one word-aligned request
//               at a time to instruction memory and queues returned words,
//               each with its PC, in a 2-entry FIFO for the decode stage.
//               A redirect (taken branch) flushes the FIFO and restarts
//               fetching at the new address. A request that is still
//               outstanding when the redirect arrives is drained, and its
//               data is dropped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC      first fetch address after reset (word aligned)
//   DEPTH         instruction buffer entries (fixed at 2)
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   mem_req_o     fetch request (registered)
//   mem_addr_o    word-aligned fetch address (registered)
//   mem_ack_i     memory accepts the request; mem_data_i valid this cycle
//   mem_data_i    fetched instruction word
//   instr_valid_o buffer head holds a valid instruction
//   instr_o       head instruction
//   pc_o          address of the head instruction
//   instr_ready_i consumer takes the head this cycle
//   redirect_i    taken branch: flush and refetch
//   redirect_pc_i new fetch address (bits[1:0] ignored)
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [2:0]  DEPTH_W   = 3'(DEPTH);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q,    state_d;
    logic        mem_req_q,  mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q,    count_d;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [31:0] buf_data_q [DEPTH];
    logic [31:0] buf_pc_q   [DEPTH];

    logic        push;
    logic        pop;
    logic        ack;
    logic        room_after_ack;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc_inc;

    // Head of the FIFO is a mux of registers only, so these outputs have
    // no combinational path from any input.
    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = buf_data_q[rd_ptr_q];
    assign pc_o          = buf_pc_q[rd_ptr_q];
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;

    // Masking (rather than slicing) keeps every bit of the port in use.
    assign redirect_pc  = redirect_pc_i & WORD_MASK;
    assign fetch_pc_inc = fetch_pc_q + 32'd4;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ack  = mem_req_q & mem_ack_i;
        // Redirect outranks both FIFO operations; DRAIN data is never pushed.
        push = (state_q == S_REQ) & mem_ack_i & ~redirect_i;
        pop  = instr_valid_o & instr_ready_i & ~redirect_i;

        if (redirect_i) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end

        // Another request may only be launched if its data is guaranteed
        // a free slot: count + outstanding never exceeds DEPTH.
        room_after_ack = (({1'b0, count_d} + 3'd1) <= DEPTH_W);

        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc;
                end else if ({1'b0, count_q} < DEPTH_W) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end

            S_REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    if (ack) begin
                        // Ack data belongs to the old path: dropped.
                        mem_addr_d = redirect_pc;
                    end else begin
                        // Address must stay stable until the ack arrives.
                        state_d = S_DRAIN;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_inc;
                    if (room_after_ack) begin
                        mem_addr_d = fetch_pc_inc;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end

            S_DRAIN: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    if (ack) begin
                        state_d    = S_REQ;
                        mem_addr_d = redirect_pc;
                    end
                end else if (ack) begin
                    // FIFO is empty here (flushed by the redirect), so a
                    // new request always has room.
                    state_d    = S_REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            fetch_pc_q <= RESET_PC & WORD_MASK;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= 32'd0;
                buf_pc_q[i]   <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;

            if (redirect_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    buf_data_q[wr_ptr_q] <= mem_data_i;
                    buf_pc_q[wr_ptr_q]   <= mem_addr_q;
                    wr_ptr_q             <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. The
//               memory model returns the bitwise inverse of the requested
//               address, so every expected instruction is ~pc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_data_i    (mem_data),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .pc_o          (pc),
        .instr_ready_i (instr_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    assign mem_data = ~mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: the rising edge happens, then outputs are sampled on the
    // falling edge where the next inputs are also applied.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        tick();

        // ---------------- reset state ----------------
        chk("rst_req",   {31'd0, mem_req},     32'd0);
        chk("rst_addr",  mem_addr,             32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_pc",    pc,                   32'd0);

        // ---------------- streaming, ack=1 ready=1 ----------------
        rst         = 1'b0;
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("s_req0",   {31'd0, mem_req},     32'd1);
        chk("s_addr0",  mem_addr,             32'd0);
        chk("s_valid0", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("s_addr1",  mem_addr,             32'd4);
        chk("s_valid1", {31'd0, instr_valid}, 32'd1);
        chk("s_pc1",    pc,                   32'd0);
        chk("s_instr1", instr,                32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s_addr_k",  mem_addr,             32'd8 + 32'(4 * k));
            chk("s_pc_k",    pc,                   32'd4 + 32'(4 * k));
            chk("s_valid_k", {31'd0, instr_valid}, 32'd1);
        end

        // ---------------- backpressure fills buffer ----------------
        do_reset();
        mem_ack = 1'b1;
        tick();
        chk("bp_req0",  {31'd0, mem_req}, 32'd1);
        chk("bp_addr0", mem_addr,         32'd0);
        tick();
        chk("bp_addr1", mem_addr, 32'd4);
        chk("bp_pc1",   pc,       32'd0);
        tick();
        chk("bp_req_full", {31'd0, mem_req},     32'd0);
        chk("bp_valid",    {31'd0, instr_valid}, 32'd1);
        chk("bp_pc_full",  pc,                   32'd0);
        tick();
        chk("bp_req_hold", {31'd0, mem_req}, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp_pc_pop", pc,                 32'd4);
        chk("bp_instr",  instr,              ~32'd4);
        tick();
        chk("bp_req8",  {31'd0, mem_req}, 32'd1);
        chk("bp_addr8", mem_addr,         32'd8);
        tick();
        chk("bp_req_full2", {31'd0, mem_req}, 32'd0);
        chk("bp_pc_hold",   pc,               32'd4);

        // ---------------- redirect before ack -> DRAIN ----------------
        do_reset();
        instr_ready = 1'b1;
        tick();
        chk("dr_addr0", mem_addr, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        mem_ack     = 1'b1;
        tick();
        redirect = 1'b0;
        mem_ack  = 1'b0;
        chk("dr_addr10",  mem_addr,             32'h10);
        chk("dr_valid_a", {31'd0, instr_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("dr_hold_addr", mem_addr,             32'h10);
        chk("dr_hold_req",  {31'd0, mem_req},     32'd1);
        chk("dr_valid_b",   {31'd0, instr_valid}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("dr_wait_addr",  mem_addr,             32'h10);
            chk("dr_wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("dr_addr40",  mem_addr,             32'h40);
        chk("dr_req40",   {31'd0, mem_req},     32'd1);
        chk("dr_drop10",  {31'd0, instr_valid}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("dr_valid40", {31'd0, instr_valid}, 32'd1);
        chk("dr_pc40",    pc,                   32'h40);
        chk("dr_instr40", instr,                ~32'h40);

        // ---------------- redirect with ack in same cycle ----------------
        do_reset();
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("ra_addr8", mem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        tick();
        redirect = 1'b0;
        chk("ra_addr20", mem_addr,             32'h20);
        chk("ra_empty",  {31'd0, instr_valid}, 32'd0);
        tick();
        chk("ra_valid20", {31'd0, instr_valid}, 32'd1);
        chk("ra_pc20",    pc,                   32'h20);

        // ---------------- address wrap ----------------
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        chk("wr_addr_f8", mem_addr,             32'hFFFF_FFF8);
        chk("wr_empty",   {31'd0, instr_valid}, 32'd0);
        tick();
        chk("wr_addr_fc", mem_addr, 32'hFFFF_FFFC);
        chk("wr_pc_f8",   pc,       32'hFFFF_FFF8);
        tick();
        chk("wr_addr_0", mem_addr, 32'h0);
        chk("wr_pc_fc",  pc,       32'hFFFF_FFFC);
        tick();
        chk("wr_pc_0",    pc,    32'h0);
        chk("wr_instr_0", instr, 32'hFFFF_FFFF);

        // ---------------- asynchronous reset mid-request ----------------
        do_reset();
        mem_ack = 1'b1;
        tick();
        tick();
        chk("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
        chk("ar_pre_addr",  mem_addr,             32'd4);
        mem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req",   {31'd0, mem_req},     32'd0);
        chk("ar_addr",  mem_addr,             32'd0);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_instr", instr,                32'd0);
        chk("ar_pc",    pc,                   32'd0);
        tick();
        rst = 1'b0;
        chk("ar_rel_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("ar_first_req",  {31'd0, mem_req},     32'd1);
        chk("ar_first_addr", mem_addr,             32'd0);
        chk("ar_no_stale",   {31'd0, instr_valid}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ar_pc0",    pc,                   32'd0);
        chk("ar_valid0", {31'd0, instr_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
